// File: rtl/alarm_fsm.sv
// Alarm sequencer: HH:MM compare, ARMED/RINGING/SNOOZE control, audio gate.
// Optional: define ALARM_BEEP_PATTERN_EN for a 1 s on / 1 s off beep.
module alarm_fsm #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int MAX_SNOOZES      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic [15:0] time_bcd,
    input  logic [15:0] alarm_bcd,
    input  logic        alarm_en,
    input  logic        snooze_btn,
    input  logic        stop_btn,
    output logic [1:0]  state,
    output logic        ringing,
    output logic        audio_gate,
    output logic [2:0]  snoozes_left
);

    localparam logic [1:0] S_DIS  = 2'b00;
    localparam logic [1:0] S_ARM  = 2'b01;
    localparam logic [1:0] S_RING = 2'b10;
    localparam logic [1:0] S_SNZ  = 2'b11;

    localparam int RING_W = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int SNZ_W  = $clog2(SNOOZE_SEC + 1);
    localparam int LEFT_W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;

    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_SEC - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SEC - 1);
    localparam logic [LEFT_W-1:0] LEFT_MAX  = LEFT_W'(MAX_SNOOZES);

    logic en_s1, en_s2;
    logic sn_s1, sn_s2, sn_s3;
    logic st_s1, st_s2, st_s3;
    logic match, match_q;

    logic              snooze_ev, stop_ev, match_rise;
    logic [1:0]        state_d;
    logic [RING_W-1:0] ring_t, ring_t_d;
    logic [SNZ_W-1:0]  snz_t, snz_t_d;
    logic [LEFT_W-1:0] left_q, left_d;
    logic              gate_d;
    logic [31:0]       left_w;

    // Two-flop synchronisers plus a third stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_s1 <= 1'b0;
            en_s2 <= 1'b0;
            sn_s1 <= 1'b0;
            sn_s2 <= 1'b0;
            sn_s3 <= 1'b0;
            st_s1 <= 1'b0;
            st_s2 <= 1'b0;
            st_s3 <= 1'b0;
        end else begin
            en_s1 <= alarm_en;
            en_s2 <= en_s1;
            sn_s1 <= snooze_btn;
            sn_s2 <= sn_s1;
            sn_s3 <= sn_s2;
            st_s1 <= stop_btn;
            st_s2 <= st_s1;
            st_s3 <= st_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            match   <= (time_bcd == alarm_bcd);
            match_q <= match;
        end
    end

    assign snooze_ev  = sn_s2 & ~sn_s3;
    assign stop_ev    = st_s2 & ~st_s3;
    assign match_rise = match & ~match_q;

    always_comb begin
        state_d  = state;
        ring_t_d = ring_t;
        snz_t_d  = snz_t;
        left_d   = left_q;
        if (!en_s2) begin
            state_d = S_DIS;
        end else begin
            case (state)
                S_DIS: begin
                    state_d = S_ARM;
                    left_d  = LEFT_MAX;
                end
                S_ARM: begin
                    if (match_rise) state_d = S_RING;
                end
                S_RING: begin
                    if (stop_ev) begin
                        state_d = S_ARM;
                        left_d  = LEFT_MAX;
                    end else if (snooze_ev && left_q != '0) begin
                        state_d = S_SNZ;
                        left_d  = left_q - LEFT_W'(1);
                    end else if (tick_1hz) begin
                        if (ring_t == RING_LAST) begin
                            state_d = S_ARM;
                            left_d  = LEFT_MAX;
                        end else begin
                            ring_t_d = ring_t + RING_W'(1);
                        end
                    end
                end
                default: begin
                    if (stop_ev) begin
                        state_d = S_ARM;
                        left_d  = LEFT_MAX;
                    end else if (tick_1hz) begin
                        if (snz_t == SNZ_LAST) state_d = S_RING;
                        else snz_t_d = snz_t + SNZ_W'(1);
                    end
                end
            endcase
        end
        // Every state entry starts both timers from zero
        if (state_d != state) begin
            ring_t_d = '0;
            snz_t_d  = '0;
        end
    end

`ifdef ALARM_BEEP_PATTERN_EN
    logic beep_q, beep_d;

    always_comb begin
        beep_d = beep_q;
        if (state_d == S_RING) begin
            if (state != S_RING) beep_d = 1'b1;
            else if (tick_1hz)   beep_d = ~beep_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beep_q <= 1'b0;
        else        beep_q <= beep_d;
    end

    assign gate_d = (state_d == S_RING) & beep_d;
`else
    assign gate_d = (state_d == S_RING);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_DIS;
            ring_t     <= '0;
            snz_t      <= '0;
            left_q     <= LEFT_MAX;
            ringing    <= 1'b0;
            audio_gate <= 1'b0;
        end else begin
            state      <= state_d;
            ring_t     <= ring_t_d;
            snz_t      <= snz_t_d;
            left_q     <= left_d;
            ringing    <= (state_d == S_RING);
            audio_gate <= gate_d;
        end
    end

    // Display value saturates at 7 for large MAX_SNOOZES
    assign left_w       = 32'(left_q);
    assign snoozes_left = (left_w > 32'd7) ? 3'd7 : left_w[2:0];

endmodule

// File: tb/tb_alarm_fsm.sv
// Randomised bench for alarm_fsm against a second-counting reference model.
// Runs with SNOOZE_SEC=3, RING_TIMEOUT_SEC=4, MAX_SNOOZES=1, tick every 10 clk.
module tb_alarm_fsm;

    localparam int SNZ = 3;
    localparam int TO  = 4;
    localparam int MAXS = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1hz = 1'b0;
    logic [15:0] time_bcd = 16'h0700;
    logic [15:0] alarm_bcd = 16'h0701;
    logic        alarm_en = 1'b0;
    logic        snooze_btn = 1'b0;
    logic        stop_btn = 1'b0;
    logic [1:0]  state;
    logic        ringing;
    logic        audio_gate;
    logic [2:0]  snoozes_left;

    int checks = 0;
    int failures = 0;
    int tcnt = 0;

    alarm_fsm #(
        .SNOOZE_SEC(SNZ),
        .RING_TIMEOUT_SEC(TO),
        .MAX_SNOOZES(MAXS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick_1hz(tick_1hz),
        .time_bcd(time_bcd),
        .alarm_bcd(alarm_bcd),
        .alarm_en(alarm_en),
        .snooze_btn(snooze_btn),
        .stop_btn(stop_btn),
        .state(state),
        .ringing(ringing),
        .audio_gate(audio_gate),
        .snoozes_left(snoozes_left)
    );

    always #5 clk = ~clk;

    // Reference model: seconds remaining, snoozes remaining, beep phase
    int m_st;
    int m_left;
    int m_ring_rem;
    int m_snz_rem;
    bit m_beep;
    bit en_h[3];
    bit sn_h[3];
    bit st_h[3];
    bit c_h[2];

    task automatic model_reset();
        m_st = 0;
        m_left = MAXS;
        m_ring_rem = 0;
        m_snz_rem = 0;
        m_beep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en_h[i] = 0;
            sn_h[i] = 0;
            st_h[i] = 0;
        end
        c_h[0] = 0;
        c_h[1] = 0;
    endtask

    task automatic enter_ring();
        m_st = 2;
        m_ring_rem = TO;
        m_beep = 1'b1;
    endtask

    task automatic go_armed();
        m_st = 1;
        m_left = MAXS;
    endtask

    task automatic model_step();
        bit en_s, sn_ev, st_ev, rise;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // Buttons are seen two edges late; edges need the sample before that
        en_s  = en_h[1];
        sn_ev = sn_h[1] & ~sn_h[2];
        st_ev = st_h[1] & ~st_h[2];
        rise  = c_h[0] & ~c_h[1];
        if (!en_s) begin
            m_st = 0;
        end else if (m_st == 0) begin
            go_armed();
        end else if (m_st == 1) begin
            if (rise) enter_ring();
        end else if (m_st == 2) begin
            if (st_ev) go_armed();
            else if (sn_ev && m_left > 0) begin
                m_st = 3;
                m_left--;
                m_snz_rem = SNZ;
            end else if (tick_1hz) begin
                m_ring_rem--;
                if (m_ring_rem == 0) go_armed();
                else m_beep = ~m_beep;
            end
        end else begin
            if (st_ev) go_armed();
            else if (tick_1hz) begin
                m_snz_rem--;
                if (m_snz_rem == 0) enter_ring();
            end
        end
        for (int i = 2; i > 0; i--) begin
            en_h[i] = en_h[i-1];
            sn_h[i] = sn_h[i-1];
            st_h[i] = st_h[i-1];
        end
        en_h[0] = alarm_en;
        sn_h[0] = snooze_btn;
        st_h[0] = stop_btn;
        c_h[1] = c_h[0];
        c_h[0] = (time_bcd == alarm_bcd);
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit exp_gate;
`ifdef ALARM_BEEP_PATTERN_EN
        exp_gate = (m_st == 2) && m_beep;
`else
        exp_gate = (m_st == 2);
`endif
        check("state", 32'(state), 32'(m_st));
        check("ringing", 32'(ringing), 32'(m_st == 2));
        check("audio_gate", 32'(audio_gate), 32'(exp_gate));
        check("snoozes_left", 32'(snoozes_left), 32'((m_left > 7) ? 7 : m_left));
    endtask

    task automatic step();
        tick_1hz = (tcnt == 9);
        tcnt = (tcnt + 1) % 10;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_snooze();
        snooze_btn = 1'b1;
        run(3);
        snooze_btn = 1'b0;
        run(2);
    endtask

    task automatic press_stop();
        stop_btn = 1'b1;
        run(3);
        stop_btn = 1'b0;
        run(2);
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int budget,
                              input string tag);
        int n = 0;
        while (state !== tgt && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(state), 32'(tgt));
    endtask

    task automatic retrigger();
        time_bcd = 16'h0700;
        run(5);
        time_bcd = 16'h0701;
        run(2);
        check("retrig_state", 32'(state), 32'h2);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        run(3);
        check("rst_state", 32'(state), 32'h0);
        check("rst_gate", 32'(audio_gate), 32'h0);
        check("rst_left", 32'(snoozes_left), 32'(MAXS));
        rst_n = 1'b1;
        alarm_en = 1'b1;
        run(10);
        check("armed", 32'(state), 32'h1);

        // Trigger: two clocks after the time reaches the alarm
        time_bcd = 16'h0701;
        step();
        check("trig_1clk", 32'(state), 32'h1);
        step();
        check("trig_2clk", 32'(state), 32'h2);
        check("trig_ring", 32'(ringing), 32'h1);
        check("trig_gate", 32'(audio_gate), 32'h1);

        // Timeout after four ticks, no re-trigger in the same minute
        run(45);
        check("timeout", 32'(state), 32'h1);
        run(30);
        check("no_retrig", 32'(state), 32'h1);

        // Snooze, re-ring, ignored second snooze, stop
        retrigger();
        press_snooze();
        check("snz_state", 32'(state), 32'h3);
        check("snz_left", 32'(snoozes_left), 32'h0);
        wait_state(2'b10, 40, "snz_rering");
        press_snooze();
        check("snz_ignored", 32'(state), 32'h2);
        press_stop();
        check("stop_state", 32'(state), 32'h1);
        check("stop_left", 32'(snoozes_left), 32'h1);

        // Stop and snooze on the same clock
        retrigger();
        stop_btn = 1'b1;
        snooze_btn = 1'b1;
        run(3);
        stop_btn = 1'b0;
        snooze_btn = 1'b0;
        run(2);
        check("prio_state", 32'(state), 32'h1);
        check("prio_left", 32'(snoozes_left), 32'h1);

        // Disable mid-ring lands three clocks after the pin change
        retrigger();
        alarm_en = 1'b0;
        run(2);
        check("dis_2clk", 32'(state), 32'h2);
        step();
        check("dis_3clk", 32'(state), 32'h0);
        alarm_en = 1'b1;
        run(6);

        // Asynchronous reset mid-ring
        retrigger();
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'h0);
        check("arst_ring", 32'(ringing), 32'h0);
        check("arst_gate", 32'(audio_gate), 32'h0);
        model_reset();
        @(negedge clk);
        run(3);
        rst_n = 1'b1;
        run(10);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(499) == 0) alarm_en = ~alarm_en;
            if ($urandom_range(24) == 0) snooze_btn = ~snooze_btn;
            if ($urandom_range(29) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(14) == 0) begin
                case ($urandom_range(3))
                    0, 1: time_bcd = 16'h0701;
                    2: time_bcd = 16'h0700;
                    default: time_bcd = 16'($urandom);
                endcase
            end
            if ($urandom_range(299) == 0)
                alarm_bcd = ($urandom_range(1) == 0) ? 16'h0701 : 16'($urandom);
            if ($urandom_range(1999) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                @(negedge clk);
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
